hilo_pipeline: RTL

- Downstream consumer of the multicycle mult/div unit's hi/lo results and of MTHI/MTLO operands.
- Carries pending HI/LO writes through two internal stages (M, W) aligned with the core's memory and writeback stages.
- Commits the writes to the architectural HI/LO registers and forwards the youngest pending value to MFHI/MFLO in execute.
- Generates no stalls itself; the execute stage waits on the multicycle ok before asserting e_valid.

---
 rtl/hilo_pipeline.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hilo_pipeline.sv
// HI/LO write pipeline: carries pending HI/LO writes through M and W, commits
// them to the architectural registers and forwards the youngest value to MFHI/MFLO.
module hilo_pipeline #(
  parameter int unsigned FORWARD = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             e_valid,
  input  logic             e_hi_we,
  input  logic             e_lo_we,
  input  logic [WIDTH-1:0] e_hi,
  input  logic [WIDTH-1:0] e_lo,
  input  logic             m_flush,
  input  logic             stall,
  output logic [WIDTH-1:0] rd_hi,
  output logic [WIDTH-1:0] rd_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             pending
);

  logic             r_m_valid;
  logic             r_m_hi_we;
  logic             r_m_lo_we;
  logic [WIDTH-1:0] r_m_hi;
  logic [WIDTH-1:0] r_m_lo;

  logic             r_w_valid;
  logic             r_w_hi_we;
  logic             r_w_lo_we;
  logic [WIDTH-1:0] r_w_hi;
  logic [WIDTH-1:0] r_w_lo;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_m_live;
  logic             w_m_fwd_hi;
  logic             w_m_fwd_lo;
  logic             w_w_hi_act;
  logic             w_w_lo_act;

  // A flush kills M in the same cycle it is raised, so M is only usable when unflushed.
  assign w_m_live   = r_m_valid & ~m_flush;
  assign w_m_fwd_hi = w_m_live & r_m_hi_we;
  assign w_m_fwd_lo = w_m_live & r_m_lo_we;
  assign w_w_hi_act = r_w_valid & r_w_hi_we;
  assign w_w_lo_act = r_w_valid & r_w_lo_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_hi_we <= 1'b0;
      r_m_lo_we <= 1'b0;
      r_m_hi    <= '0;
      r_m_lo    <= '0;
    end else if (!stall) begin
      r_m_valid <= e_valid;
      r_m_hi_we <= e_hi_we;
      r_m_lo_we <= e_lo_we;
      r_m_hi    <= e_hi;
      r_m_lo    <= e_lo;
    end else if (m_flush) begin
      // Flush still kills M while the pipe is frozen.
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_w_valid <= 1'b0;
      r_w_hi_we <= 1'b0;
      r_w_lo_we <= 1'b0;
      r_w_hi    <= '0;
      r_w_lo    <= '0;
    end else if (!stall) begin
      r_w_valid <= w_m_live;
      r_w_hi_we <= r_m_hi_we;
      r_w_lo_we <= r_m_lo_we;
      r_w_hi    <= r_m_hi;
      r_w_lo    <= r_m_lo;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!stall) begin
      if (w_w_hi_act) begin
        r_hi <= r_w_hi;
      end
      if (w_w_lo_act) begin
        r_lo <= r_w_lo;
      end
    end
  end

  generate
    if (FORWARD != 0) begin : g_forward
      // M is younger than W, so it takes priority for each half independently.
      always_comb begin
        rd_hi = r_hi;
        if (w_m_fwd_hi) begin
          rd_hi = r_m_hi;
        end else if (w_w_hi_act) begin
          rd_hi = r_w_hi;
        end
      end

      always_comb begin
        rd_lo = r_lo;
        if (w_m_fwd_lo) begin
          rd_lo = r_m_lo;
        end else if (w_w_lo_act) begin
          rd_lo = r_w_lo;
        end
      end
    end else begin : g_no_forward
      assign rd_hi = r_hi;
      assign rd_lo = r_lo;
    end
  endgenerate

  assign pending = (r_m_valid & (r_m_hi_we | r_m_lo_we)) |
                   (r_w_valid & (r_w_hi_we | r_w_lo_we));

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
